// File: rtl/glitchcore_pkg.sv
// Shared definitions for glitchcore blocks: FSM state encoding and synchronizer depth.
package glitchcore_pkg;

   localparam int unsigned SYNC_STAGES = 2;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARMED = 3'd1,
      ST_DELAY = 3'd2,
      ST_PULSE = 3'd3,
      ST_GAP   = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   function automatic logic state_is_busy(input state_t s);
      return !((s == ST_IDLE) || (s == ST_DONE));
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Multi-flop level synchronizer (default two stages), asynchronous active-high reset.
module sync_2ff
   import glitchcore_pkg::*;
#(
   parameter int unsigned STAGES = SYNC_STAGES
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) sync_q <= '0;
      else       sync_q <= {sync_q[STAGES-2:0], d_i};
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/glitch_pulse_gen.sv
// Triggered glitch pulse generator: armed, delayed, width-controlled pulse on pulse_o.
// Define GLITCH_PULSE_REPEAT_EN to enable repeated pulses separated by gap cycles.
module glitch_pulse_gen
   import glitchcore_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             trigger_i,
   input  logic             arm_i,
   input  logic [WIDTH-1:0] delay_i,
   input  logic [WIDTH-1:0] width_i,
   input  logic [WIDTH-1:0] gap_i,
   input  logic [WIDTH-1:0] repeat_i,
   output logic             pulse_o,
   output logic             busy_o,
   output logic             done_o
);

   localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

   state_t state_q, state_d;

   logic                   trig_sync;
   logic                   trig_prev_q;
   logic [SYNC_STAGES-1:0] fill_q;
   logic                   trig_edge;

   logic [WIDTH-1:0] delay_q, width_q;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             load_cfg;
   logic             go_pulse;
   logic             pulse_q, done_q;

`ifdef GLITCH_PULSE_REPEAT_EN
   logic [WIDTH-1:0] gap_q, rep_q;
   logic [WIDTH-1:0] rep_cnt_q, rep_cnt_d;
`else
   logic unused_repeat_cfg;
   assign unused_repeat_cfg = ^{gap_i, repeat_i};
`endif

   sync_2ff #(
      .STAGES (SYNC_STAGES)
   ) u_trig_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (trigger_i),
      .q_o   (trig_sync)
   );

   // The previous-level flop is held high until the synchronizer has refilled after reset,
   // so a trigger level already high at release never reads as a rising edge.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fill_q      <= '0;
         trig_prev_q <= 1'b1;
      end else begin
         fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
         trig_prev_q <= (&fill_q) ? trig_sync : 1'b1;
      end
   end

   assign trig_edge = trig_sync & ~trig_prev_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         delay_q <= '0;
         width_q <= '0;
`ifdef GLITCH_PULSE_REPEAT_EN
         gap_q   <= '0;
         rep_q   <= '0;
`endif
      end else if (load_cfg) begin
         delay_q <= delay_i;
         width_q <= width_i;
`ifdef GLITCH_PULSE_REPEAT_EN
         gap_q   <= gap_i;
         rep_q   <= repeat_i;
`endif
      end
   end

   // Counters are only ever loaded with non-zero values; the phase ends when they reach one.
   // NOTE: every signal driven here gets a default first so no latch can be inferred.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      load_cfg = 1'b0;
      go_pulse = 1'b0;
`ifdef GLITCH_PULSE_REPEAT_EN
      rep_cnt_d = rep_cnt_q;
`endif

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (arm_i) begin
               load_cfg = 1'b1;
               state_d  = ST_ARMED;
            end
         end
         ST_ARMED: begin
            if (trig_edge) begin
`ifdef GLITCH_PULSE_REPEAT_EN
               rep_cnt_d = rep_q;
`endif
               if (delay_q != '0) begin
                  state_d = ST_DELAY;
                  cnt_d   = delay_q;
               end else begin
                  go_pulse = 1'b1;
               end
            end
         end
         ST_DELAY: begin
            if (cnt_q == CNT_ONE) go_pulse = 1'b1;
            else                  cnt_d    = cnt_q - CNT_ONE;
         end
         ST_PULSE: begin
            if (cnt_q != CNT_ONE) begin
               cnt_d = cnt_q - CNT_ONE;
            end else begin
`ifdef GLITCH_PULSE_REPEAT_EN
               if (rep_cnt_q != '0) begin
                  rep_cnt_d = rep_cnt_q - CNT_ONE;
                  if (gap_q == '0) begin
                     state_d = ST_PULSE;
                     cnt_d   = width_q;
                  end else begin
                     state_d = ST_GAP;
                     cnt_d   = gap_q;
                  end
               end else begin
                  state_d = ST_DONE;
               end
`else
               state_d = ST_DONE;
`endif
            end
         end
`ifdef GLITCH_PULSE_REPEAT_EN
         ST_GAP: begin
            if (cnt_q == CNT_ONE) begin
               state_d = ST_PULSE;
               cnt_d   = width_q;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase

      if (go_pulse) begin
         if (width_q == '0) begin
            state_d = ST_DONE;
         end else begin
            state_d = ST_PULSE;
            cnt_d   = width_q;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         pulse_q <= 1'b0;
         done_q  <= 1'b0;
`ifdef GLITCH_PULSE_REPEAT_EN
         rep_cnt_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pulse_q <= (state_d == ST_PULSE);
         done_q  <= (state_d == ST_DONE);
`ifdef GLITCH_PULSE_REPEAT_EN
         rep_cnt_q <= rep_cnt_d;
`endif
      end
   end

   assign pulse_o = pulse_q;
   assign done_o  = done_q;
   assign busy_o  = state_is_busy(state_q);

endmodule

// File: doc/glitch_pulse_gen.md
GLITCH_PULSE_GEN -- requirements
Module: glitch_pulse_gen

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the width of the delay, pulse-width, gap and repeat registers and counters.
REQ-002 clk_i  input  1  SHALL be the system clock; all state SHALL change on its rising edge, except on reset.
REQ-003 rst_i  input  1  SHALL be the reset: asynchronous, active-high.
REQ-004 trigger_i  input  1  SHALL be the trigger level from the upstream asynchronous event counter; it is asynchronous to clk_i.
REQ-005 arm_i  input  1  SHALL be a single-cycle request that samples the configuration inputs and arms the block.
REQ-006 delay_i  input  WIDTH  SHALL be the number of cycles from trigger edge detection to the first pulse.
REQ-007 width_i  input  WIDTH  SHALL be the pulse high time, in cycles.
REQ-008 gap_i  input  WIDTH  SHALL be the low time between repeated pulses, in cycles (used only with repeat).
REQ-009 repeat_i  input  WIDTH  SHALL be the number of additional pulses after the first (used only with repeat).
REQ-010 pulse_o  output  1  SHALL be the registered glitch pulse output.
REQ-011 busy_o  output  1  SHALL be high in every state except IDLE and DONE.
REQ-012 done_o  output  1  SHALL be a sticky completion flag.

Function
REQ-013 trigger_i SHALL pass through a 2-FF synchronizer; a rising edge on the synchronized level SHALL be detected in the cycle it appears (cycle T).
REQ-014 FSM states SHALL be IDLE, ARMED, DELAY, PULSE, GAP and DONE.
REQ-015 In IDLE or DONE, arm_i SHALL latch delay_i, width_i, gap_i and repeat_i, clear done_o and enter ARMED on the next cycle.
REQ-016 arm_i SHALL be ignored in ARMED, DELAY, PULSE and GAP.
REQ-017 In ARMED, a trigger edge at cycle T SHALL load the delay counter and enter DELAY, or enter PULSE directly when delay = 0.
REQ-018 A trigger edge detected outside ARMED SHALL be ignored.
REQ-019 For an edge at T, pulse_o SHALL first be high in cycle T+1+delay.
REQ-020 pulse_o SHALL stay high for exactly width consecutive cycles.
REQ-021 width = 0 SHALL produce no pulse: the block SHALL go from DELAY/ARMED straight to DONE, with pulse_o never high.
REQ-022 After the last pulse the block SHALL enter DONE; done_o SHALL be high from the first cycle after the last pulse cycle and hold until the next accepted arm_i or reset.
REQ-023 Counters SHALL count down and SHALL NOT wrap: a value of 2^WIDTH-1 SHALL give exactly 2^WIDTH-1 cycles.
REQ-024 The latched configuration SHALL be immune to input changes while busy.
REQ-025 pulse_o SHALL be driven directly from a flip-flop, with no combinational decode.

Reset
REQ-026 Asserting rst_i SHALL immediately force the state to IDLE and pulse_o, busy_o and done_o to 0, including mid-pulse.
REQ-027 Asserting rst_i SHALL clear the synchronizer and the edge detector, so a trigger_i level already high at release does not count as an edge.
REQ-028 After reset, arm_i SHALL be needed before any trigger is accepted.

Configuration
REQ-029 Macro GLITCH_PULSE_REPEAT_EN defined: after each pulse, while the remaining repeat count is > 0, the FSM SHALL enter GAP for gap cycles, then PULSE again, decrementing the count.
REQ-030 With GLITCH_PULSE_REPEAT_EN defined, gap = 0 SHALL merge consecutive pulses into one continuous high period of (repeat+1)*width cycles.
REQ-031 Macro GLITCH_PULSE_REPEAT_EN undefined: the block SHALL emit exactly one pulse; the GAP state, gap_i and repeat_i logic SHALL be absent and those inputs ignored.

Structure
REQ-032 The FSM state typedef (6 encodings) and the synchronizer depth constant (2) SHALL live in shared package glitchcore_pkg.
REQ-033 The 2-FF synchronizer SHALL be a separate sub-module, sync_2ff, with asynchronous active-high reset; it is reusable by other glitchcore blocks.

Verification
REQ-034 arm with delay=5, width=3; raise trigger_i -> pulse_o high for exactly 3 cycles starting T+6; done_o rises the next cycle; busy_o falls with it.
REQ-035 arm with delay=0, width=1 -> single 1-cycle pulse at T+1; a second trigger edge while in DONE -> no pulse.
REQ-036 arm with width=0, delay=4 -> pulse_o never high; done_o high at T+5.
REQ-037 Assert rst_i in the second cycle of a width=10 pulse -> pulse_o goes 0 asynchronously; state IDLE; trigger without re-arm -> no pulse.
REQ-038 With GLITCH_PULSE_REPEAT_EN: delay=2, width=2, gap=3, repeat=2 -> pulses at T+3..T+4, T+8..T+9, T+13..T+14; done_o at T+15.
REQ-039 Pulse arm_i mid-DELAY with new delay_i=100 -> ignored; the original timing holds.
